// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through stream FIFO sequencer around an external simple dual-port RAM
// with a 2-cycle registered read path; a small staging queue hides the read latency.
module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int PF_THRESH  = 768,
    parameter int OQ_DEPTH   = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ram_wea,
    output logic [AW-1:0]         ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_enb,
    output logic [AW-1:0]         ram_addrb,
    output logic                  ram_regceb,
    output logic                  ram_rstb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    output logic [AW:0]           level,
    output logic                  prog_full
);

    localparam int OQW = $clog2(OQ_DEPTH);
    localparam logic [AW:0]    DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]    PF_L    = (AW+1)'(PF_THRESH);
    localparam logic [OQW+1:0] OQ_L    = (OQW+2)'(OQ_DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [1:0]            pipe_q, pipe_d;
    logic [OQW-1:0]        oq_wr_q, oq_wr_d;
    logic [OQW-1:0]        oq_rd_q, oq_rd_d;
    logic [OQW:0]          oq_cnt_q, oq_cnt_d;
    logic                  s_ready_q, s_ready_d;
    logic                  prog_full_q, prog_full_d;
    logic [DATA_WIDTH-1:0] oq_mem_q [OQ_DEPTH];

    logic          push, issue, capture, pop;
    logic [AW:0]   level_d;
    logic [OQW+1:0] credit;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign push    = s_valid & s_ready_q;
    assign pop     = m_valid & m_ready;
    assign capture = pipe_q[1];
    // Words already staged plus reads in flight must fit the staging queue.
    assign credit  = (OQW+2)'(oq_cnt_q) + (OQW+2)'(pipe_q[0]) + (OQW+2)'(pipe_q[1]);
    assign issue   = (level != '0) && (credit < OQ_L);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pipe_d   = {pipe_q[0], issue};
        oq_wr_d  = oq_wr_q;
        oq_rd_d  = oq_rd_q;
        oq_cnt_d = oq_cnt_q;
        if (push)    wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (issue)   rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        if (capture) oq_wr_d  = oq_wr_q + OQW'(1);
        if (pop)     oq_rd_d  = oq_rd_q + OQW'(1);
        case ({capture, pop})
            2'b10:   oq_cnt_d = oq_cnt_q + (OQW+1)'(1);
            2'b01:   oq_cnt_d = oq_cnt_q - (OQW+1)'(1);
            default: oq_cnt_d = oq_cnt_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pipe_d   = '0;
            oq_wr_d  = '0;
            oq_rd_d  = '0;
            oq_cnt_d = '0;
        end
        level_d     = wr_ptr_d - rd_ptr_d;
        s_ready_d   = (level_d < DEPTH_L) && !flush;
        prog_full_d = (level_d >= PF_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pipe_q      <= '0;
            oq_wr_q     <= '0;
            oq_rd_q     <= '0;
            oq_cnt_q    <= '0;
            s_ready_q   <= 1'b0;
            prog_full_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pipe_q      <= pipe_d;
            oq_wr_q     <= oq_wr_d;
            oq_rd_q     <= oq_rd_d;
            oq_cnt_q    <= oq_cnt_d;
            s_ready_q   <= s_ready_d;
            prog_full_q <= prog_full_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OQ_DEPTH; i++) oq_mem_q[i] <= '0;
        end else if (capture && !flush) begin
            oq_mem_q[oq_wr_q] <= ram_doutb;
        end
    end

    assign s_ready    = s_ready_q;
    assign prog_full  = prog_full_q;
    assign m_valid    = (oq_cnt_q != '0);
    assign m_data     = oq_mem_q[oq_rd_q];
    assign ram_wea    = push;
    assign ram_addra  = wr_ptr_q[AW-1:0];
    assign ram_dina   = s_data;
    assign ram_enb    = issue;
    assign ram_addrb  = rd_ptr_q[AW-1:0];
    assign ram_regceb = 1'b1;
    assign ram_rstb   = flush;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural 2-cycle RAM, vector table, directed corner
// sequences and a queue scoreboard on the read side.
module tb_dpram_fifo_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int PF    = 12;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          ram_wea, ram_enb, ram_regceb, ram_rstb;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dina, ram_doutb;
    logic [AW:0]   level;
    logic          prog_full;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb [$];

    dpram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PF_THRESH(PF), .OQ_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_regceb(ram_regceb),
        .ram_rstb(ram_rstb), .ram_doutb(ram_doutb),
        .level(level), .prog_full(prog_full)
    );

    always #5 clk = ~clk;

    // RAM: read latch on enb, then output register; data visible 2 edges after issue
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_s1, ram_out;
    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_dina;
        if (ram_enb) ram_s1 <= mem[ram_addrb];
        if (ram_rstb) ram_out <= '0;
        else if (ram_regceb) ram_out <= ram_s1;
    end
    assign ram_doutb = ram_out;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (m_valid && m_ready) begin
                if (sb.size() == 0) check("sb_unexpected_pop", m_data, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    check("sb_data", m_data, sb[0]);
                    void'(sb.pop_front());
                end
            end
            if (s_valid && s_ready) sb.push_back(s_data);
        end
        check("prog_full_vs_level", prog_full, (level >= PF));
        if (ram_enb) check("enb_with_level0", (level != 0), 1);
    end

    typedef struct packed {
        logic          fl;
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          e_srdy;
        logic          e_mv;
        logic [DW-1:0] e_md;
        logic          chk_md;
        logic [AW:0]   e_lvl;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int sent, rcvd, gap, srdy_low, first_mv, acc, pops;
        logic took, done, pf_hi, pf_fell;

        tbl[0]  = '{1'b0, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 5'd1};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA5, 1'b1, 5'd0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0};
        tbl[5]  = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd1};
        tbl[6]  = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd1};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h11, 1'b1, 5'd0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h11, 1'b1, 5'd0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h22, 1'b1, 5'd0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0};
        tbl[12] = '{1'b1, 1'b1, 32'h33, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 5'd0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0};

        #2 rst_n = 1'b0;
        repeat (3) step();
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_level", level, 0);
        check("rst_prog_full", prog_full, 0);
        check("rst_m_data", m_data, 0);
        check("rst_ram_enb", ram_enb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_release_s_ready_low", s_ready, 0);
        step();
        check("rst_release_s_ready_rise", s_ready, 1);

        // T1 and basic cases as cycle vectors
        for (int i = 0; i < 14; i++) begin
            flush = tbl[i].fl; s_valid = tbl[i].sv; s_data = tbl[i].sd; m_ready = tbl[i].mr;
            step();
            check($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].e_srdy);
            check($sformatf("vec%0d_m_valid", i), m_valid, tbl[i].e_mv);
            check($sformatf("vec%0d_level", i), level, tbl[i].e_lvl);
            if (tbl[i].chk_md) check($sformatf("vec%0d_m_data", i), m_data, tbl[i].e_md);
        end
        flush = 0; s_valid = 0; m_ready = 0;
        step();

        // T2 throughput
        sent = 0; rcvd = 0; gap = 0; srdy_low = 0; first_mv = -1; done = 0;
        m_ready = 1;
        for (int c = 0; c < 2300 && !done; c++) begin
            s_valid = (sent < 2048);
            s_data  = sent;
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            else if (s_valid) srdy_low++;
            if (m_valid) begin
                if (first_mv < 0) first_mv = c;
                rcvd++;
            end else if (rcvd > 0 && rcvd < 2048) gap++;
            step();
            if (rcvd == 2048) done = 1;
        end
        s_valid = 0;
        check("t2_received", rcvd, 2048);
        check("t2_gaps", gap, 0);
        check("t2_s_ready_drops", srdy_low, 0);
        check("t2_first_latency", first_mv, 4);

        // T3 full
        m_ready = 0; acc = 0;
        for (int c = 0; c < 40; c++) begin
            s_valid = 1; s_data = 32'h300 + acc;
            @(negedge clk);
            took = s_ready;
            step();
            if (took) acc++;
        end
        s_valid = 0;
        check("t3_accepted", acc, 20);
        check("t3_level_full", level, 16);
        check("t3_s_ready_low", s_ready, 0);
        m_ready = 1; pops = 0;
        for (int c = 0; c < 60 && pops < 20; c++) begin
            @(negedge clk);
            if (m_valid) pops++;
            step();
        end
        check("t3_drained", pops, 20);
        m_ready = 0;
        step();

        // T5 flush with two reads in flight
        for (int i = 0; i < 10; i++) begin
            s_valid = 1; s_data = 32'h500 + i;
            step();
        end
        s_valid = 0;
        repeat (8) step();
        check("t5_level_settled", level, 6);
        m_ready = 1;
        @(negedge clk); check("t5_enb_blocked", ram_enb, 0); step();
        @(negedge clk); check("t5_enb_a", ram_enb, 1); step();
        @(negedge clk); check("t5_enb_b", ram_enb, 1); step();
        flush = 1; s_valid = 1; s_data = 32'hEE;
        step();
        flush = 0; s_valid = 0;
        check("t5_flush_m_valid", m_valid, 0);
        check("t5_flush_level", level, 0);
        check("t5_flush_s_ready", s_ready, 0);
        step();
        check("t5_s_ready_back", s_ready, 1);
        check("t5_stale_m_valid", m_valid, 0);
        s_valid = 1; s_data = 32'h77;
        step();
        s_valid = 0;
        check("t5_mv_e0", m_valid, 0);
        step(); check("t5_mv_e1", m_valid, 0);
        step(); check("t5_mv_e2", m_valid, 0);
        step(); check("t5_mv_e3", m_valid, 1);
        check("t5_first_word", m_data, 32'h77);
        step(); check("t5_popped", m_valid, 0);

        // T4 random backpressure
        for (int c = 0; c < 800; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            m_ready = ($urandom_range(0, 99) < 30);
            step();
        end
        s_valid = 0; m_ready = 1; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            step();
            if (level == 0 && !m_valid) done = 1;
        end
        check("t4_drained", done, 1);
        check("t4_sb_empty", sb.size(), 0);

        // T6 wrap and prog_full
        sent = 0; done = 0; pf_hi = 0; pf_fell = 0;
        for (int c = 0; c < 800 && !done; c++) begin
            s_valid = (sent < 100);
            s_data  = 32'h600 + sent;
            m_ready = (((c / 20) % 2) == 1);
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            if (prog_full) pf_hi = 1;
            else if (pf_hi) pf_fell = 1;
            step();
            if (sent == 100 && level == 0 && !m_valid) done = 1;
        end
        s_valid = 0;
        check("t6_done", done, 1);
        check("t6_pf_seen", pf_hi, 1);
        check("t6_pf_fell", pf_fell, 1);

        // async reset mid-transfer
        m_ready = 0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1; s_data = 32'h800 + i;
            step();
        end
        s_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_m_valid", m_valid, 0);
        check("arst_level", level, 0);
        check("arst_s_ready", s_ready, 0);
        check("arst_prog_full", prog_full, 0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst_s_ready_rise", s_ready, 1);
        s_valid = 1; s_data = 32'h99; m_ready = 1;
        step();
        s_valid = 0; done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (m_valid) begin
                check("arst_first_word", m_data, 32'h99);
                done = 1;
            end
            step();
        end
        check("arst_word_out", done, 1);
        step();
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
